// File: rtl/decodificador_pt2272.sv
// PT2272-style receiver: decodes the PT2262 serial line into 8 trinary address symbols and
// 4 data bits; D is latched and vt raised after two identical, address-matched frames.
module decodificador_pt2272 #(
    parameter int CLK_PER_CHIP = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cod_i,
    input  logic [7:0] A_01,
    input  logic [7:0] A_F,
    output logic [3:0] D,
    output logic       vt,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] dbg_state
);
    localparam int T_VT_TO = 1024 * CLK_PER_CHIP;
    localparam int TO_W    = $clog2(T_VT_TO + 1);
    localparam logic [15:0]     T_SHORT_MAX = 16'(8 * CLK_PER_CHIP);
    localparam logic [15:0]     T_LONG_MAX  = 16'(16 * CLK_PER_CHIP);
    localparam logic [15:0]     T_SYNC_MIN  = 16'(64 * CLK_PER_CHIP);
    localparam logic [TO_W-1:0] T_VT_TO_C   = TO_W'(T_VT_TO);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        RX        = 2'd1,
        SYNC_WAIT = 2'd2
    } state_t;

    state_t          state;
    logic            cod_meta, cod_sync, cod_prev;
    logic [15:0]     hi_cnt, lo_cnt;
    logic [4:0]      half_idx;
    logic [23:0]     half_bits;
    logic [23:0]     cand;
    logic            cand_valid;
    logic            seen_sync;
    logic [TO_W-1:0] to_cnt;

    logic       rise, fall, gap, timeout;
    logic       pulse_is_l, pulse_too_long, first_half;
    logic       rx_err, sw_err, frame_end;
    logic       addr_match;
    logic [3:0] rx_data;

    assign rise      = cod_sync & ~cod_prev;
    assign fall      = ~cod_sync & cod_prev;
    assign gap       = ~cod_sync && (lo_cnt == T_SYNC_MIN);
    assign timeout   = (to_cnt == T_VT_TO_C);
    assign rx_data   = {half_bits[22], half_bits[20], half_bits[18], half_bits[16]};
    assign dbg_state = state;

    // hi_cnt holds the finished pulse width during the fall cycle, then restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cod_meta <= 1'b0;
            cod_sync <= 1'b0;
            cod_prev <= 1'b0;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
        end else begin
            cod_meta <= cod_i;
            cod_sync <= cod_meta;
            cod_prev <= cod_sync;
            if (fall)
                hi_cnt <= '0;
            else if (cod_sync && hi_cnt != 16'hFFFF)
                hi_cnt <= hi_cnt + 16'd1;
            if (rise)
                lo_cnt <= '0;
            else if (!cod_sync && lo_cnt != 16'hFFFF)
                lo_cnt <= lo_cnt + 16'd1;
        end
    end

    always_comb begin
        pulse_is_l     = (hi_cnt >= T_SHORT_MAX);
        pulse_too_long = (hi_cnt >= T_LONG_MAX);
        first_half     = half_bits[{half_idx[4:1], 1'b0}];
        rx_err         = 1'b0;
        sw_err         = 1'b0;
        frame_end      = 1'b0;
        case (state)
            RX: begin
                // Second half of a symbol: LS is illegal, SL (F) is illegal in data symbols.
                if (fall)
                    rx_err = pulse_too_long ||
                             (half_idx[0] && (first_half ? !pulse_is_l
                                                         : (pulse_is_l && half_idx >= 5'd16)));
                else if (gap)
                    rx_err = 1'b1;
            end
            SYNC_WAIT: begin
                if (fall)
                    sw_err = pulse_is_l;
                else if (rise && seen_sync)
                    sw_err = 1'b1;
                else if (gap) begin
                    if (seen_sync)
                        frame_end = 1'b1;
                    else
                        sw_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Local pin setting as a half pair {second, first}: 0=SS, 1=LL, F=SL.
    always_comb begin
        logic [1:0] exp_pair;
        exp_pair   = 2'b00;
        addr_match = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_pair = A_F[k] ? 2'b10 : (A_01[k] ? 2'b11 : 2'b00);
            if ({half_bits[2*k+1], half_bits[2*k]} != exp_pair)
                addr_match = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            to_cnt <= '0;
        else if (frame_end && addr_match)
            to_cnt <= '0;
        else if (!timeout)
            to_cnt <= to_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HUNT;
            half_idx   <= '0;
            half_bits  <= '0;
            cand       <= '0;
            cand_valid <= 1'b0;
            seen_sync  <= 1'b0;
            D          <= '0;
            vt         <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (timeout && !frame_end) begin
                vt         <= 1'b0;
                cand_valid <= 1'b0;
            end
            if (rx_err || sw_err) begin
                frame_err  <= 1'b1;
                vt         <= 1'b0;
                cand_valid <= 1'b0;
                state      <= HUNT;
            end else begin
                case (state)
                    HUNT: begin
                        if (gap) begin
                            state    <= RX;
                            half_idx <= '0;
                        end
                    end
                    RX: begin
                        if (fall) begin
                            half_bits[half_idx] <= pulse_is_l;
                            if (half_idx == 5'd23) begin
                                state     <= SYNC_WAIT;
                                seen_sync <= 1'b0;
                            end else begin
                                half_idx <= half_idx + 5'd1;
                            end
                        end
                    end
                    SYNC_WAIT: begin
                        if (fall) begin
                            seen_sync <= 1'b1;
                        end else if (frame_end) begin
                            // The gap that closes this frame is the sync of the next one.
                            frame_ok  <= 1'b1;
                            state     <= RX;
                            half_idx  <= '0;
                            seen_sync <= 1'b0;
                            if (addr_match && cand_valid && half_bits == cand) begin
                                D  <= rx_data;
                                vt <= 1'b1;
                            end else begin
                                cand       <= half_bits;
                                cand_valid <= addr_match;
                                vt         <= 1'b0;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
